// File: rtl/barrett_sched.sv
// barrett_sched: round-robin front end that shares one pipelined Barrett reduction core.
// Holds the modulus configuration, issues one tagged operand per cycle and returns results with IDs.
module barrett_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [63:0]          cfg_q,
  input  logic [30:0]          cfg_mu,
  input  logic [7:0]           cfg_k,
  output logic                 cfg_err,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*128-1:0]  req_z,
  output logic [NREQ-1:0]      req_ready,
  output logic                 core_valid,
  output logic [127:0]         core_z,
  output logic [63:0]          core_q,
  output logic [30:0]          core_mu,
  output logic [7:0]           core_k,
  input  logic [63:0]          core_t,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_t,
  output logic                 idle
);

  localparam int CW = $clog2(LAT + 2);

  logic            cfg_loaded;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant_id;
  logic [127:0]    grant_z;
  logic            grant_found;
  logic            fire;
  logic            cfg_ok;
  logic [IDW-1:0]  issue_id;
  logic [LAT-1:0]  tag_v;
  logic [IDW-1:0]  tag_id [LAT];
  logic            tag_exit;
  logic [CW-1:0]   inflight;

  always_comb begin
    req_ready   = '0;
    grant_id    = '0;
    grant_z     = '0;
    grant_found = 1'b0;
    if (cfg_loaded && !cfg_we) begin
      // first pass searches [ptr, NREQ-1], second pass wraps around to [0, ptr-1]
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && (IDW'(i) >= ptr)) begin
          grant_found  = 1'b1;
          req_ready[i] = 1'b1;
          grant_id     = IDW'(i);
          grant_z      = req_z[i*128 +: 128];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i]) begin
          grant_found  = 1'b1;
          req_ready[i] = 1'b1;
          grant_id     = IDW'(i);
          grant_z      = req_z[i*128 +: 128];
        end
      end
    end
  end

  assign fire     = |(req_valid & req_ready);
  assign cfg_ok   = cfg_we && idle && !fire;
  assign tag_exit = tag_v[LAT-1];
  assign idle     = (inflight == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
      core_q     <= '0;
      core_mu    <= '0;
      core_k     <= '0;
      ptr        <= '0;
      core_valid <= 1'b0;
      core_z     <= '0;
      issue_id   <= '0;
      tag_v      <= '0;
      for (int j = 0; j < LAT; j++) tag_id[j] <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_t      <= '0;
      inflight   <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        core_q     <= cfg_q;
        core_mu    <= cfg_mu;
        core_k     <= cfg_k;
        cfg_loaded <= 1'b1;
      end

      core_valid <= fire;
      if (fire) begin
        core_z   <= grant_z;
        issue_id <= grant_id;
        ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end

      // tag rides alongside the core so it emerges in the cycle core_t is valid
      tag_v[0]  <= core_valid;
      tag_id[0] <= issue_id;
      for (int j = 1; j < LAT; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end

      rsp_valid <= tag_exit;
      if (tag_exit) begin
        rsp_id <= tag_id[LAT-1];
        rsp_t  <= core_t;
      end

      if (fire && !tag_exit)
        inflight <= inflight + CW'(1);
      else if (!fire && tag_exit)
        inflight <= inflight - CW'(1);
    end
  end

endmodule

// File: doc/barrett_sched.md
# barrett_sched

Round-robin scheduler sharing one pipelined Barrett reduction core among `NREQ` requesters. It holds the shared modulus configuration (`q`, `mu`, `k`) and accepts one `z` operand per cycle through a valid/ready handshake. It drives the core's operand port and tags every issued operation, then returns each core result `t` with the originating requester ID. It sits between the requesting datapaths and the reduction core.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters (2..8).
- `LAT`, default 3: core latency in cycles, from `core_valid` high to the matching `core_t` valid (≥1).
- `IDW`, default 2: requester ID width; must be ≥ clog2(`NREQ`).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_we`  in  1  load `cfg_q`, `cfg_mu`, `cfg_k`.
- `cfg_q`  in  64  modulus.
- `cfg_mu`  in  31  Barrett constant.
- `cfg_k`  in  8  shift amount.
- `cfg_err`  out  1  one-cycle pulse when a `cfg_we` is rejected.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_z`  in  NREQ*128  flattened operands; requester i uses bits [128*i+127:128*i].
- `req_ready`  out  NREQ  one-hot grant, combinational.
- `core_valid`  out  1  operand issue strobe to the core.
- `core_z`  out  128  operand to the core.
- `core_q`  out  64  configuration register to the core.
- `core_mu`  out  31  configuration register to the core.
- `core_k`  out  8  configuration register to the core.
- `core_t`  in  64  core result, sampled `LAT` cycles after `core_valid`.
- `rsp_valid`  out  1  result strobe, one cycle wide.
- `rsp_id`  out  IDW  requester ID of the result.
- `rsp_t`  out  64  result value.
- `idle`  out  1  high when no operation is in flight.

## Operation

- **Configuration:**
  - `cfg_loaded` is cleared by reset.
  - `cfg_we` is accepted only when `idle`=1 and no request fires in the same cycle. On acceptance, the `core_q`/`core_mu`/`core_k` registers update and `cfg_loaded` is set.
  - Otherwise the write is dropped and `cfg_err` pulses in the next cycle.
- **Arbitration:**
  - No grants are issued while `cfg_loaded`=0 or while a `cfg_we` is present.
  - Otherwise `req_ready` grants exactly one valid requester. The search starts at `ptr` and wraps modulo `NREQ`.
  - Fire = `req_valid[i] & req_ready[i]`. After a fire, `ptr` = granted index + 1 (mod `NREQ`); `ptr` is unchanged when nothing fires.
  - At most one fire per cycle. `req_ready` never goes high for a requester whose `req_valid`=0.
- **Issue:** on a fire, `core_z` is registered from the winning slice and `core_valid`=1 in the next cycle. Otherwise `core_valid`=0 and `core_z` holds its value.
- **Tag pipeline:**
  - A shift register of depth `LAT` carries {valid, id} alongside the core.
  - When the tag emerges with valid=1, `core_t` is registered into `rsp_t`, the id goes to `rsp_id`, and `rsp_valid` is set.
  - There is no response backpressure; consumers must accept every response.
- **In-flight counter:**
  - Width clog2(`LAT`+2).
  - +1 on a fire, −1 when a tag exits. Both in one cycle leave it unchanged.
  - `idle` = (count == 0).
- **Width rules:** `core_t` is forwarded unmodified. The scheduler performs no arithmetic on operands.
- **Reset, mid-operation or otherwise:**
  - Clears `ptr`, `cfg_loaded`, the tag pipe and the counter.
  - All outputs read 0 from the cycle after the reset edge: `core_*` registers 0, `rsp_*` 0, `cfg_err` 0, `req_ready` 0, `idle` 1.
  - Core results still in flight at reset are discarded, because their tags are cleared.

## Timing

- Fire in cycle n → `core_valid` in n+1 → `core_t` valid in n+1+`LAT` → `rsp_valid` in n+2+`LAT`.
- Total latency is `LAT`+2 cycles.
- Throughput is one operation per cycle. Results return in issue order.
- Configuration is accepted in cycle n and is visible on `core_q`/`core_mu`/`core_k` in cycle n+1; the earliest fire is in n+1.
- With a single continuously valid requester, it is granted every cycle. With all `NREQ` valid, each requester is granted exactly once every `NREQ` cycles.

## Test plan

Bench uses a behavioural core of latency `LAT`=3 returning `z mod q`.

1. **Basic reduction.**
   - Stimulus: reset, then cfg q=768112, mu=1431447, k=20; requester 0 sends z=365183773 once.
   - Required: `rsp_valid` exactly 5 cycles after the fire with `rsp_id`=0 and `rsp_t`=330573; `idle` returns to 1.
2. **Round-robin fairness.**
   - Stimulus: all four requesters valid continuously for 8 cycles.
   - Required: grant order 0,1,2,3,0,1,2,3; responses return in the same order with each result equal to its `z mod q`.
3. **Configuration rules.**
   - `cfg_we` while an operation is in flight → `cfg_err` pulses and `core_q` is unchanged.
   - After `idle`, cfg q=768009, then z=365183661 → `rsp_t`=379386.
   - `cfg_we` before any configuration → no `req_ready` until it is accepted.
4. **Reset mid-flight.**
   - Stimulus: issue 3 ops back to back, then assert `rst_n`=0 for 1 cycle two cycles after the last fire.
   - Required: no `rsp_valid` afterwards, `idle`=1, `ptr` back at 0 (requester 0 is granted first), and `cfg_loaded`=0 so no grants until reconfigured.
5. **Sparse/simultaneous events.**
   - Stimulus: requester 2 alone toggles valid every other cycle while a response exits in a fire cycle.
   - Required: the counter stays correct, `idle` goes high only after the last response, and there is no spurious grant to a requester with `req_valid`=0.
